// File: rtl/serial_pkg.sv
// Shared types for the serial job queue: FSM states, word width helper
// and the packed request entry carried through the request FIFO.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN
    } state_t;

    function automatic int word_width(input int base);
        return 1 << base;
    endfunction

    localparam int DATA_WIDTH_BASE = 5;
    localparam int DATA_W = word_width(DATA_WIDTH_BASE);

    typedef struct packed {
        logic              mode;
        logic [DATA_W-1:0] data;
    } req_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with combinational head read.
// Push is dropped when full, pop is dropped when empty.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_job_queue.sv
// Job scheduler in front of the serial core: queues requests, launches them
// one at a time via start/busy, and buffers received words for the consumer.
module serial_job_queue
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH_BASE = 5,
    parameter int DEPTH_LOG2      = 2,
    parameter int START_TIMEOUT   = 15
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_mode,
    input  logic [word_width(DATA_WIDTH_BASE)-1:0] req_data,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [word_width(DATA_WIDTH_BASE)-1:0] rsp_data,
    output logic                             core_start,
    output logic                             core_mode,
    output logic [word_width(DATA_WIDTH_BASE)-1:0] core_transmit_data,
    input  logic                             core_busy,
    input  logic                             core_finish,
    input  logic [word_width(DATA_WIDTH_BASE)-1:0] core_receive_data,
    output logic                             idle,
    output logic                             err_timeout
);

    localparam int W  = word_width(DATA_WIDTH_BASE);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    state_t              state;
    logic [TW-1:0]       timer;
    req_entry_t          req_in;
    req_entry_t          head;
    logic                req_full;
    logic                req_empty;
    logic                req_pop;
    logic                rsp_full;
    logic                rsp_empty;
    logic                rsp_push;
    logic [DEPTH_LOG2:0] req_count;
    logic [DEPTH_LOG2:0] rsp_count;
    logic                unused;

    assign req_in    = '{mode: req_mode, data: req_data};
    assign req_ready = !req_full;
    assign rsp_valid = !rsp_empty;
    assign idle      = (state == IDLE) && req_empty;
    assign unused    = ^{core_finish, req_count, rsp_count};

    // Receive jobs wait while the response FIFO is full so it never overflows.
    assign req_pop  = (state == IDLE) && !req_empty
                   && (!head.mode || !rsp_full);
    assign rsp_push = (state == RUN) && !core_busy && core_mode;

    sync_fifo #(
        .WIDTH      (W + 1),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (req_valid),
        .pop     (req_pop),
        .wr_data (req_in),
        .rd_data (head),
        .full    (req_full),
        .empty   (req_empty),
        .count   (req_count)
    );

    sync_fifo #(
        .WIDTH      (W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rsp_push),
        .pop     (rsp_ready),
        .wr_data (core_receive_data),
        .rd_data (rsp_data),
        .full    (rsp_full),
        .empty   (rsp_empty),
        .count   (rsp_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            timer              <= '0;
            core_start         <= 1'b0;
            core_mode          <= 1'b0;
            core_transmit_data <= '0;
            err_timeout        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_pop) begin
                        core_mode          <= head.mode;
                        core_transmit_data <= head.data;
                        timer              <= '0;
                        state              <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // Timer counts only cycles in which start is visible.
                    if (!core_start) begin
                        core_start <= 1'b1;
                    end else if (core_busy) begin
                        core_start <= 1'b0;
                        state      <= RUN;
                    end else if (timer == TW'(START_TIMEOUT - 1)) begin
                        core_start  <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RUN: begin
                    if (!core_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_job_queue.md
# serial_job_queue

Upstream job scheduler for the serial full-duplex core (`TOP`). It buffers transmit and receive requests in a small request FIFO, launches them one at a time through the core's `start`/`mode` handshake, and stores completed receive words in a response FIFO. Software-side logic sees two valid/ready streams instead of the core's raw `start`/`busy` protocol.

## Interface
- `DATA_WIDTH_BASE`, 5: word width W = 2**DATA_WIDTH_BASE. This must match the core.
- `DEPTH_LOG2`, 2: each FIFO holds 2**DEPTH_LOG2 entries.
- `START_TIMEOUT`, 15: maximum cycles `core_start` is held waiting for `core_busy`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request offered.
- `req_ready` out 1: request FIFO not full.
- `req_mode` in 1: 1 = receive job, 0 = transmit job.
- `req_data` in W: word to transmit. Ignored for receive jobs.
- `rsp_valid` out 1: response FIFO not empty.
- `rsp_ready` in 1: consumer pops the head.
- `rsp_data` out W: head of the response FIFO.
- `core_start` out 1: drives the core's `start`.
- `core_mode` out 1: drives the core's `mode`.
- `core_transmit_data` out W: drives the core's `transmit_data`.
- `core_busy` in 1: the core's `busy`.
- `core_finish` in 1: the core's `finish`. Unused for sequencing; reserved.
- `core_receive_data` in W: the core's `receive_data`.
- `idle` out 1: FSM is in IDLE and the request FIFO is empty.
- `err_timeout` out 1: sticky; set when a launch times out, cleared only by `rst`.

## Operation
- A request is accepted on an edge where `req_valid && req_ready`. The pushed entry is {`req_mode`, `req_data`}.
- A response is popped on an edge where `rsp_valid && rsp_ready`.
- FSM states are IDLE, LAUNCH and RUN.
- **IDLE**
  - If the request FIFO is non-empty and (head mode = 0 or the response FIFO is not full), pop the head into the job registers, clear the timer, and go to LAUNCH.
  - A receive job is never launched while the response FIFO is full. Because only one job is in flight, this guarantees the response FIFO cannot overflow.
- **LAUNCH**
  - Drive `core_start` = 1, with `core_mode` and `core_transmit_data` taken from the job registers.
  - If `core_busy` = 1, go to RUN.
  - Otherwise increment the timer. When the timer reaches `START_TIMEOUT`, set `err_timeout`, discard the job, and go to IDLE.
- **RUN**
  - `core_start` = 0. `core_mode` and `core_transmit_data` are held stable.
  - When `core_busy` = 0: for a receive job, push `core_receive_data` into the response FIFO on that edge. Then go to IDLE.
- `core_mode` and `core_transmit_data` change only when a new job is popped. They hold their last values while idle.

## Timing
- Reset values:
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0 (all FIFO storage is cleared).
  - `core_start` = 0, `core_mode` = 0, `core_transmit_data` = 0.
  - `idle` = 1, `err_timeout` = 0, FSM in IDLE.
- Latency: with the FSM idle and both FIFOs empty, a request accepted at edge N gives `core_start` = 1 from edge N+2.
- `core_start` stays high through the first cycle in which `core_busy` = 1 is sampled, then drops at the next edge.
- A receive word is visible on `rsp_data`/`rsp_valid` one edge after `core_busy` is sampled low in RUN.
- There is at least one IDLE cycle between consecutive jobs.
- The FIFOs are first-word fall-through, with combinational read of the head.
- Request FIFO: when full, `req_ready` = 0 even if a pop occurs in the same cycle.
- Response FIFO: a simultaneous push and pop is legal when it is neither full nor empty. The count is unchanged.
- Pointers wrap modulo 2**DEPTH_LOG2. Each count is DEPTH_LOG2+1 bits wide.
- Reset asserted mid-job: the FSM returns to IDLE, both FIFOs are cleared, and `core_start` drops on the reset edge. The core shares `rst`, so no recovery handshake is needed.

## Structure
- Package `serial_pkg` holds:
  - the state enum {IDLE, LAUNCH, RUN};
  - a width helper returning 2**DATA_WIDTH_BASE;
  - the request-entry packed type {mode, data}.
- Sub-module `sync_fifo` (parameters WIDTH and DEPTH_LOG2; outputs full, empty and count) is instantiated twice:
  - request FIFO, WIDTH = W+1;
  - response FIFO, WIDTH = W.
- The FSM, timer and job registers live in the top level.

## Test plan
The bench uses a core model that raises `busy` 2 cycles after `start` and holds it for 66 cycles.
- Transmit job, data 32'hDEAD_BEEF:
  - `core_start` high for exactly 3 cycles (2 waiting, plus the cycle `busy` is sampled);
  - `core_mode` = 0 and `core_transmit_data` = 32'hDEAD_BEEF for the whole job;
  - no response; `idle` = 1 afterwards.
- Receive job, model returns 32'h1234_5678: exactly one response with `rsp_data` = 32'h1234_5678, and `core_mode` = 1 during the job.
- Back-to-back pushes of 6 transmit jobs while the model is busy: exactly 5 accepted (1 in flight plus 4 queued), then `req_ready` = 0. All 5 execute in order.
- 5 receive jobs with `rsp_ready` = 0: 4 responses queue, and the 5th job's `core_start` stays 0. One pop launches it; the data order is preserved.
- Model never asserts `busy`: `core_start` is high for 15 cycles, then `err_timeout` = 1. The following queued job still runs normally.
- `rst` pulsed for 1 cycle during RUN with 3 jobs queued: all outputs return to their reset values next cycle, and no queued job launches afterwards.
